// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between pipeline control and md_unit.
//   Start : request to launch Op this cycle
//   Op    : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   A, B  : operands rs (RD1) and rt (RD2)
//   Busy  : a mult/div is in flight
//   HI/LO : architectural HI/LO registers
// master = pipeline side, slave = md_unit.
interface md_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, Op, A, B, input Busy, HI, LO);
  modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit holding HI/LO, with a fixed-latency busy
// counter so the pipeline can stall on Busy/Start.
// Ports:
//   Clk   : clock, all state updates on posedge
//   Reset : synchronous active-high reset
//   bus   : md_unit_if.slave (Start, Op, A, B in; Busy, HI, LO out)
// Parameters:
//   MULT_CYCLES : busy cycles for mult/multu (>=1)
//   DIV_CYCLES  : busy cycles for div/divu (>=1)
// Build option:
//   MDU_DIVZERO_HOLD_EN : when defined, div/divu by zero leaves HI/LO
//   unchanged; otherwise it writes HI=dividend, LO=all ones.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     Clk,
  input  logic     Reset,
  md_unit_if.slave bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  op_e              op_q, op_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;

  op_e  op_in;
  logic accept, is_md, is_mul, done;

  assign op_in  = op_e'(bus.Op);
  assign accept = bus.Start && (state_q == S_IDLE);
  assign is_md  = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                  (op_in == OP_DIV)  || (op_in == OP_DIVU);
  assign is_mul = (op_in == OP_MULT) || (op_in == OP_MULTU);
  assign done   = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NONE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_md) state_d = S_BUSY;
      S_BUSY:  if (done)            state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result computation from the latched operands
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] a_mag, b_mag, b_safe_s, b_safe_u;
  logic        [31:0] q_mag, r_mag, div_q, div_r, divu_q, divu_r;
  logic               b_zero;
  logic        [31:0] res_hi, res_lo;

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    b_zero   = (b_q == '0);
    a_mag    = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag    = b_q[31] ? (32'd0 - b_q) : b_q;
    b_safe_s = b_zero ? 32'd1 : b_mag;
    b_safe_u = b_zero ? 32'd1 : b_q;
    q_mag    = a_mag / b_safe_s;
    r_mag    = a_mag % b_safe_s;
    div_q    = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    div_r    = a_q[31] ? (32'd0 - r_mag) : r_mag;
    divu_q   = a_q / b_safe_u;
    divu_r   = a_q % b_safe_u;

    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = div_r;  res_lo = div_q;  end
      OP_DIVU:  begin res_hi = divu_r; res_lo = divu_q; end
      default:  begin res_hi = hi_q;   res_lo = lo_q;   end
    endcase

    if (b_zero && ((op_q == OP_DIV) || (op_q == OP_DIVU))) begin
`ifdef MDU_DIVZERO_HOLD_EN
      res_hi = hi_q;
      res_lo = lo_q;
`else
      res_hi = a_q;
      res_lo = '1;
`endif
    end
  end

  // Datapath next values: counter, operand latches, HI/LO
  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    hi_d  = hi_q;
    lo_d  = lo_q;

    if (accept && is_md) begin
      cnt_d = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      a_d   = bus.A;
      b_d   = bus.B;
      op_d  = op_in;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (accept && (op_in == OP_MTHI)) hi_d = bus.A;
    if (accept && (op_in == OP_MTLO)) lo_d = bus.A;

    if (done) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  // Outputs
  always_comb begin
    bus.Busy = (state_q == S_BUSY);
    bus.HI   = hi_q;
    bus.LO   = lo_q;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit that consumes the two register-file read ports (RD1/RD2) and serves the mult/multu/div/divu/mthi/mtlo/mfhi/mflo instructions. It sits directly downstream of the general register file, in parallel with the ALU. It holds the HI/LO architectural registers and models realistic latency with a busy counter, so the pipeline control stalls on Busy/Start.

## Interface
Parameters:
- MULT_CYCLES, 5: busy duration of mult/multu in cycles (≥1).
- DIV_CYCLES, 10: busy duration of div/divu in cycles (≥1).

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request to launch the operation in Op this cycle.
- Op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  operand rs (from RD1).
- B  input  32  operand rt (from RD2).
- Busy  output  1  high while a mult/div is in flight.
- HI  output  32  HI register (mfhi source).
- LO  output  32  LO register (mflo source).

## Operation
- Reset (sampled at posedge): Busy=0, HI=0, LO=0, internal counter=0, operand latches=0. Reset overrides everything, including an operation in flight, which is discarded.
- Accept condition: Start=1 and Busy=0 at a posedge. Start while Busy=1 is ignored, with no queueing. Op 0/7 with Start is ignored.
- Op 1–4 on accept:
  - Latch A, B and Op.
  - Busy=1; counter loaded with MULT_CYCLES (ops 1, 2) or DIV_CYCLES (ops 3, 4).
  - A/B may change afterwards without effect.
- While Busy: counter decrements each edge. At the edge where the counter equals 1:
  - HI/LO are written with the result.
  - Busy=0 and counter=0.
- Results:
  - mult: {HI,LO} = signed 64-bit product of A and B.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
    - Overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: LO = A/B, HI = A%B, both unsigned.
- mthi (5) / mtlo (6) on accept: HI (resp. LO) ← A at that same edge. Busy stays 0 and the other register is unchanged.
- HI/LO hold their values at all times except at reset, the completion edge, or an mthi/mtlo edge.
- Division by zero (B=0 on div/divu): full DIV_CYCLES latency still applies; the result is given under Configuration.

## Timing
- Accept at edge k. Busy is high for cycles k+1 … k+N, where N = MULT_CYCLES or DIV_CYCLES.
- At edge k+N, HI/LO update and Busy falls together. New HI/LO are visible combinationally in cycle k+N+1.
- Earliest next accept is edge k+N+1, which makes back-to-back operations possible with no dead cycle. A Start at edge k+N is still rejected, because Busy=1 is sampled.
- mthi/mtlo: value visible the cycle after the accept edge; zero busy cycles.
- Pipeline control rule: stall any md instruction (including mfhi/mflo) when Busy=1 or Start=1 in the consuming stage.
- Reset at any edge k+j (1≤j≤N) of an operation: Busy=0 and HI=LO=0 after that edge, and no result is ever written.

## Configuration
- MDU_DIVZERO_HOLD_EN:
  - Defined: div/divu with B=0 completes after DIV_CYCLES but leaves HI and LO unchanged.
  - Undefined: B=0 writes HI=A (latched dividend) and LO=32'hFFFFFFFF for both div and divu.

## Test plan
- Reset then idle: assert Reset one edge → Busy=0, HI=0, LO=0; Start with Op=0 for 3 cycles → nothing changes.
- mult signed: A=0xFFFFFFFE (−2), B=3, Start, Op=1 → Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. The same operands with Op=2 (multu) → HI=0x00000002, LO=0xFFFFFFFA.
- div signed: A=0xFFFFFFF9 (−7), B=2, Op=3 → Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with 7/2 → LO=3, HI=1.
- Start while busy: launch multu 5×6; at busy cycle 2 issue mtlo with A=0x1234 → ignored; final HI=0, LO=30. The next mtlo, issued the cycle after Busy falls → LO=0x1234, HI unchanged.
- Reset mid-op: launch div 100/7; assert Reset at busy cycle 4 → Busy=0, HI=LO=0, and no write occurs at the former completion edge.
- Divide by zero: mthi A=0xAAAA, mtlo A=0x5555; then div A=9, B=0 → after 10 cycles, with the macro defined HI=0xAAAA, LO=0x5555; without it HI=9, LO=0xFFFFFFFF.
